// File: rtl/dht_report_sequencer.sv
// dht_report_sequencer: turns a DHT11 sample into an ASCII report line fed byte by byte to a UART.
module dht_report_sequencer #(
    parameter int EOL_CR  = 1,
    parameter int HOLDOFF = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] data,
    input  logic        datavalid,
    input  logic        txdone,
    output logic [7:0]  txbyte,
    output logic        senddata,
    output logic        busy,
    output logic        overrun
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CHECK = 3'd1;
    localparam logic [2:0] CONV  = 3'd2;
    localparam logic [2:0] LOAD  = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
    localparam logic [2:0] NEXT  = 3'd5;
    localparam int HW = $clog2(HOLDOFF + 2);

    logic [2:0]    state;
    logic [39:0]   work, pend;
    logic          pend_v, err, phase;
    logic [3:0]    idx, ht, hu, tt, tu, tens, last;
    logic [6:0]    val;
    logic [HW-1:0] hold;
    logic [7:0]    hold_byte, cur, sum, eol;
    logic          hold_done, last_byte;

    function automatic logic [6:0] clamp(input logic [7:0] x);
        return x > 8'd99 ? 7'd99 : x[6:0];
    endfunction

    always_comb begin
        sum = work[39:32] + work[31:24] + work[23:16] + work[15:8];
        hold_done = hold == '0;
        eol = EOL_CR != 0 ? 8'h0D : 8'h0A;
        last = err ? (EOL_CR != 0 ? 4'd4 : 4'd3) : (EOL_CR != 0 ? 4'd8 : 4'd7);
        last_byte = idx == last;
        cur = 8'h0A;
        if (err)
            case (idx)
                4'd0: cur = 8'h45;
                4'd1, 4'd2: cur = 8'h52;
                4'd3: cur = eol;
                default: cur = 8'h0A;
            endcase
        else
            case (idx)
                4'd0: cur = 8'h48;
                4'd1: cur = {4'h3, ht};
                4'd2: cur = {4'h3, hu};
                4'd3: cur = 8'h20;
                4'd4: cur = 8'h54;
                4'd5: cur = {4'h3, tt};
                4'd6: cur = {4'h3, tu};
                4'd7: cur = eol;
                default: cur = 8'h0A;
            endcase
    end

    assign senddata = state == LOAD;
    assign busy     = state != IDLE;
    assign txbyte   = senddata ? cur : hold_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            work      <= '0;
            pend      <= '0;
            pend_v    <= 1'b0;
            err       <= 1'b0;
            phase     <= 1'b0;
            idx       <= '0;
            ht        <= '0;
            hu        <= '0;
            tt        <= '0;
            tu        <= '0;
            tens      <= '0;
            val       <= '0;
            hold      <= HW'(HOLDOFF);
            hold_byte <= '0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (!hold_done) hold <= hold - HW'(1);
            // default: any sample arriving now is parked; consuming branches below override
            if (datavalid) begin
                pend    <= data;
                pend_v  <= 1'b1;
                overrun <= pend_v;
            end
            case (state)
                IDLE: if (hold_done && (datavalid || pend_v)) begin
                    work    <= datavalid ? data : pend;
                    pend_v  <= 1'b0;
                    overrun <= datavalid && pend_v;
                    state   <= CHECK;
                end
                CHECK: begin
                    idx   <= '0;
                    err   <= sum != work[7:0];
                    val   <= clamp(work[39:32]);
                    tens  <= '0;
                    phase <= 1'b0;
                    state <= sum == work[7:0] ? CONV : LOAD;
                end
                CONV: if (val >= 7'd10) begin
                    val  <= val - 7'd10;
                    tens <= tens + 4'd1;
                end else if (!phase) begin
                    ht    <= tens;
                    hu    <= val[3:0];
                    val   <= clamp(work[23:16]);
                    tens  <= '0;
                    phase <= 1'b1;
                end else begin
                    tt    <= tens;
                    tu    <= val[3:0];
                    state <= LOAD;
                end
                LOAD: begin
                    hold_byte <= cur;
                    state     <= WAIT;
                end
                WAIT: if (txdone) state <= NEXT;
                NEXT: if (!last_byte) begin
                    idx   <= idx + 4'd1;
                    state <= LOAD;
                end else if (datavalid || pend_v) begin
                    work    <= datavalid ? data : pend;
                    pend_v  <= 1'b0;
                    overrun <= datavalid && pend_v;
                    state   <= CHECK;
                end else
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
